// File: rtl/prog_timer.sv
// prog_timer: programmable one-shot/periodic timer with prescaler and expiry pulse
module prog_timer #(
  parameter int WIDTH      = 21,
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START_TMR,
  input  logic                  STOP_TMR,
  input  logic                  MODE,
  input  logic [WIDTH-1:0]      PERIOD,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  PULSE,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      COUNT
);
  typedef enum logic {S_IDLE, S_COUNT} state_t;
  state_t state, state_n;
  logic mode_q, mode_n, pulse_n, start_ok, tick, expire;
  logic [WIDTH-1:0] per_q, per_n, cnt_n;
  logic [PRESCALE_W-1:0] psc_q, psc_n, pre_q, pre_n;
  // next state: STOP beats START, START beats expiry; cfg only latched on an accepted START
  always_comb begin
    start_ok = START_TMR && !STOP_TMR;
    tick     = pre_q == psc_q;
    expire   = tick && COUNT == per_q;
    state_n  = state;
    mode_n   = mode_q;
    per_n    = per_q;
    psc_n    = psc_q;
    cnt_n    = COUNT;
    pre_n    = pre_q;
    pulse_n  = 1'b0;
    if (start_ok) begin
      state_n = S_COUNT;
      mode_n  = MODE;
      per_n   = PERIOD;
      psc_n   = PRESCALE;
      cnt_n   = '0;
      pre_n   = '0;
    end else if (state == S_COUNT) begin
      if (STOP_TMR) begin
        state_n = S_IDLE;
        cnt_n   = '0;
        pre_n   = '0;
      end else begin
        pre_n   = tick ? '0 : pre_q + 1'b1;
        cnt_n   = expire ? '0 : tick ? COUNT + 1'b1 : COUNT;
        pulse_n = expire;
        state_n = (expire && !mode_q) ? S_IDLE : S_COUNT;
      end
    end
  end
  // state, latched configuration and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      per_q  <= '0;
      psc_q  <= '0;
      pre_q  <= '0;
      COUNT  <= '0;
      PULSE  <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      per_q  <= per_n;
      psc_q  <= psc_n;
      pre_q  <= pre_n;
      COUNT  <= cnt_n;
      PULSE  <= pulse_n;
      BUSY   <= state_n == S_COUNT;
    end
  end
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed self-checking bench for prog_timer
module tb_prog_timer;
  localparam int W = 12;
  localparam int PW = 8;
  logic CLK = 1'b0, RST = 1'b1, START_TMR = 1'b0, STOP_TMR = 1'b0, MODE = 1'b0;
  logic [W-1:0] PERIOD = '0;
  logic [PW-1:0] PRESCALE = '0;
  logic PULSE, BUSY;
  logic [W-1:0] COUNT;
  int n_tests = 0, n_fail = 0;
  int np, at, bad;

  prog_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .START_TMR(START_TMR), .STOP_TMR(STOP_TMR), .MODE(MODE),
    .PERIOD(PERIOD), .PRESCALE(PRESCALE), .PULSE(PULSE), .BUSY(BUSY), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (PULSE) pulses++;
    end
  endtask

  task automatic start(input logic m, input int n, input int p);
    MODE = m;
    PERIOD = W'(n);
    PRESCALE = PW'(p);
    START_TMR = 1'b1;
    step();
    START_TMR = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_pulse", 32'(PULSE), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_count", 32'(COUNT), 0);
    RST = 1'b0;

    start(1'b0, 100, 0);
    run(10, np);
    check("midrun_count", 32'(COUNT), 10);
    check("midrun_busy", 32'(BUSY), 1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_busy", 32'(BUSY), 0);
    check("async_rst_count", 32'(COUNT), 0);
    check("async_rst_pulse", 32'(PULSE), 0);
    step();
    RST = 1'b0;
    run(150, np);
    check("after_rst_pulses", 32'(np), 0);

    start(1'b0, 9, 0);
    check("os_start_busy", 32'(BUSY), 1);
    check("os_start_count", 32'(COUNT), 0);
    PERIOD = W'(3);
    MODE = 1'b1;
    run(9, np);
    check("os_pre_pulses", 32'(np), 0);
    check("os_pre_count", 32'(COUNT), 9);
    step();
    check("os_pulse", 32'(PULSE), 1);
    check("os_busy_fall", 32'(BUSY), 0);
    check("os_count_clr", 32'(COUNT), 0);
    run(30, np);
    check("os_no_repeat", 32'(np), 0);

    start(1'b1, 3, 4);
    np = 0;
    bad = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i == 7) check("per_presc_count", 32'(COUNT), 1);
      if (PULSE) np++;
      if (PULSE != (i % 20 == 0)) bad++;
    end
    check("per_pulses", 32'(np), 5);
    check("per_spacing", 32'(bad), 0);
    STOP_TMR = 1'b1;
    step();
    STOP_TMR = 1'b0;
    check("per_stop_busy", 32'(BUSY), 0);
    check("per_stop_count", 32'(COUNT), 0);
    run(60, np);
    check("per_stop_pulses", 32'(np), 0);

    start(1'b0, 50, 0);
    run(20, np);
    check("rs_count20", 32'(COUNT), 20);
    start(1'b0, 5, 0);
    check("rs_count_clr", 32'(COUNT), 0);
    check("rs_busy", 32'(BUSY), 1);
    run(5, np);
    check("rs_pre_pulses", 32'(np), 0);
    step();
    check("rs_pulse", 32'(PULSE), 1);
    run(60, np);
    check("rs_no_old_expiry", 32'(np), 0);

    start(1'b1, 4, 0);
    run(4, np);
    check("stopexp_count", 32'(COUNT), 4);
    STOP_TMR = 1'b1;
    step();
    STOP_TMR = 1'b0;
    check("stopexp_pulse", 32'(PULSE), 0);
    check("stopexp_busy", 32'(BUSY), 0);
    run(20, np);
    check("stopexp_after", 32'(np), 0);

    START_TMR = 1'b1;
    STOP_TMR = 1'b1;
    step();
    check("ss_idle_busy", 32'(BUSY), 0);
    step();
    START_TMR = 1'b0;
    STOP_TMR = 1'b0;
    run(20, np);
    check("ss_idle_pulses", 32'(np), 0);
    check("ss_idle_busy2", 32'(BUSY), 0);

    start(1'b1, 2, 0);
    run(2, np);
    start(1'b1, 3, 0);
    check("startexp_pulse", 32'(PULSE), 0);
    check("startexp_count", 32'(COUNT), 0);
    run(3, np);
    check("startexp_count3", 32'(COUNT), 3);
    check("startexp_nopulse", 32'(np), 0);
    step();
    check("startexp_newpulse", 32'(PULSE), 1);
    STOP_TMR = 1'b1;
    step();
    STOP_TMR = 1'b0;

    start(1'b1, 0, 0);
    bad = 0;
    run(10, np);
    check("n0_every_cycle", 32'(np), 10);
    check("n0_count", 32'(COUNT), 0);
    STOP_TMR = 1'b1;
    step();
    STOP_TMR = 1'b0;
    check("n0_stop_pulse", 32'(PULSE), 0);

    start(1'b0, (1 << W) - 1, 0);
    np = 0;
    at = 0;
    bad = 0;
    for (int i = 1; i <= (1 << W) + 20; i++) begin
      step();
      if (PULSE) begin
        np++;
        at = i;
      end
      if (i < (1 << W) && 32'(COUNT) != i) bad++;
    end
    check("max_pulses", 32'(np), 1);
    check("max_pulse_at", 32'(at), 1 << W);
    check("max_count_track", 32'(bad), 0);
    check("max_end_count", 32'(COUNT), 0);
    check("max_end_busy", 32'(BUSY), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
